lbm_chunk_scheduler: RTL and testbench
======================================

LBM_CHUNK_SCHEDULER -- requirements
Module: lbm_chunk_scheduler

Interface
REQ-001 SHALL have parameter NUM_CHUNKS, default 4, chunks per lattice step (>=1).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default `ADDRESS_WIDTH, per-bank BRAM address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle run request, sampled only in IDLE.
REQ-006 SHALL have port num_steps, input, 16, steps to run, latched on accepted start.
REQ-007 SHALL have ports chunk_transfer_ready (output, 1) and ld_done (input, 1): load request level and loader completion pulse.
REQ-008 SHALL have ports ld_bank (output, 1) and ld_chunk (output, $clog2(NUM_CHUNKS) min 1): target bank and chunk index of the load.
REQ-009 SHALL have ports chunk_compute_ready (output, 1) and cp_done (input, 1): solver request level and solver completion pulse.
REQ-010 SHALL have ports cp_bank (output, 1) and cp_chunk (output, same width as ld_chunk).
REQ-011 SHALL have ports ld_addr, cp_addr (input, ADDRESS_WIDTH) and ld_we, cp_we (input, 1): requester BRAM accesses.
REQ-012 SHALL have ports bank_addr0, bank_addr1 (output, ADDRESS_WIDTH) and bank_we (output, 2): muxed per-bank BRAM ports.
REQ-013 SHALL have ports step_count (output, 16), busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-014 SHALL number jobs k = 0..T-1 with T = NUM_CHUNKS*num_steps, where job k is chunk k mod NUM_CHUNKS in bank k mod 2.
REQ-015 SHALL implement FSM IDLE, PRIME, OVERLAP, LAST, FINISH.
REQ-016 IDLE: on start with num_steps=0 SHALL go to FINISH; on start with T=1 SHALL go to PRIME; otherwise SHALL go to PRIME.
REQ-017 PRIME SHALL request the load of job 0 only; on ld_done it SHALL go to OVERLAP if T>1, else to LAST.
REQ-018 OVERLAP SHALL request the load of job k+1 and the compute of job k together, with ld_bank != cp_bank.
REQ-019 OVERLAP SHALL latch each done pulse into a sticky flag, and SHALL advance only when both flags are set, including the same-cycle case.
REQ-020 On advance, k SHALL increment and the flags SHALL clear; the state SHALL stay OVERLAP while k+1<T-1 before the increment, else go to LAST.
REQ-021 LAST SHALL request the compute of job T-1 only; on cp_done it SHALL go to FINISH.
REQ-022 FINISH SHALL pulse done for one cycle and then return to IDLE.
REQ-023 Each request SHALL deassert in the cycle its done pulse is sampled, and the next request SHALL assert exactly 1 cycle after the advancing edge.
REQ-024 ld_done or cp_done arriving while the matching request is low SHALL be ignored.
REQ-025 start arriving outside IDLE SHALL be ignored.
REQ-026 step_count SHALL increment when a compute of chunk NUM_CHUNKS-1 completes, wrap modulo 2^16, and clear on accepted start.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 bank_addrN SHALL be ld_addr when chunk_transfer_ready and ld_bank=N, else cp_addr when chunk_compute_ready and cp_bank=N, else 0.
REQ-029 bank_we[N] SHALL follow the same selection, gated by the matching request.
REQ-030 Bank selection SHALL be combinational, with zero latency from requester address/we to BRAM port.

Reset
REQ-031 While rstn=0, the FSM SHALL be in IDLE, and all outputs, k, flags, step_count and latched num_steps SHALL be 0.
REQ-032 Reset mid-run SHALL abort immediately, with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-033 State encoding and the LBM_NUM_CHUNKS default SHALL reside in the shared def.vh package.
REQ-034 The bank address/we mux SHALL be one sub-module, lbm_bank_mux; the FSM and counters SHALL stay in the top.

Verification
REQ-035 NUM_CHUNKS=4, num_steps=2, ld_done/cp_done 5 cycles after each request -> 8 loads and 8 computes, banks alternate 0,1,0,1, step_count=2, done once.
REQ-036 In OVERLAP, ld_done and cp_done in the same cycle -> both requests reassert exactly 1 cycle later, with chunk indices +1.
REQ-037 cp_done 10 cycles before ld_done -> no advance until ld_done; chunk_compute_ready stays low during the wait.
REQ-038 start with num_steps=0 -> done pulses 2 cycles after start, with no requests asserted.
REQ-039 rstn low during OVERLAP of job 3 -> all outputs 0 asynchronously; a new start reruns from job 0.
REQ-040 Random ld_we/cp_we traffic -> bank_we never sets both banks from one requester, and never routes to the wrong bank versus ld_bank/cp_bank.

Source files
------------

// File: rtl/lbm_chunk_scheduler_pkg.sv
// Shared definitions for the LBM chunk scheduler: FSM encoding and defaults.
package lbm_chunk_scheduler_pkg;

  localparam int LBM_NUM_CHUNKS    = 4;
  localparam int LBM_ADDRESS_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_OVERLAP = 3'd2,
    ST_LAST    = 3'd3,
    ST_FINISH  = 3'd4
  } sched_state_t;

  // Width of a chunk index; a single chunk still needs one bit.
  function automatic int chunk_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lbm_chunk_scheduler_bank_mux.sv
// Routes the loader and solver BRAM accesses to the two ping-pong banks.
module lbm_bank_mux #(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     ld_req,
  input  logic                     ld_bank,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic                     ld_we,
  input  logic                     cp_req,
  input  logic                     cp_bank,
  input  logic [ADDRESS_WIDTH-1:0] cp_addr,
  input  logic                     cp_we,
  output logic [ADDRESS_WIDTH-1:0] bank_addr0,
  output logic [ADDRESS_WIDTH-1:0] bank_addr1,
  output logic [1:0]               bank_we
);

  // Loader has priority on a bank; an idle requester never reaches a bank.
  always_comb begin
    bank_addr0 = '0;
    bank_addr1 = '0;
    bank_we    = '0;
    if (ld_req && !ld_bank) begin
      bank_addr0 = ld_addr;
      bank_we[0] = ld_we;
    end else if (cp_req && !cp_bank) begin
      bank_addr0 = cp_addr;
      bank_we[0] = cp_we;
    end
    if (ld_req && ld_bank) begin
      bank_addr1 = ld_addr;
      bank_we[1] = ld_we;
    end else if (cp_req && cp_bank) begin
      bank_addr1 = cp_addr;
      bank_we[1] = cp_we;
    end
  end

endmodule

// File: rtl/lbm_chunk_scheduler.sv
// Double-buffered chunk scheduler: overlaps the load of job k+1 with the
// compute of job k, alternating BRAM banks between consecutive jobs.
module lbm_chunk_scheduler
  import lbm_chunk_scheduler_pkg::*;
#(
  parameter int NUM_CHUNKS    = LBM_NUM_CHUNKS,
  parameter int ADDRESS_WIDTH = LBM_ADDRESS_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [15:0]                          num_steps,
  output logic                                 chunk_transfer_ready,
  input  logic                                 ld_done,
  output logic                                 ld_bank,
  output logic [chunk_idx_w(NUM_CHUNKS)-1:0]   ld_chunk,
  output logic                                 chunk_compute_ready,
  input  logic                                 cp_done,
  output logic                                 cp_bank,
  output logic [chunk_idx_w(NUM_CHUNKS)-1:0]   cp_chunk,
  input  logic [ADDRESS_WIDTH-1:0]             ld_addr,
  input  logic [ADDRESS_WIDTH-1:0]             cp_addr,
  input  logic                                 ld_we,
  input  logic                                 cp_we,
  output logic [ADDRESS_WIDTH-1:0]             bank_addr0,
  output logic [ADDRESS_WIDTH-1:0]             bank_addr1,
  output logic [1:0]                           bank_we,
  output logic [15:0]                          step_count,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CW = chunk_idx_w(NUM_CHUNKS);
  localparam int JW = 16 + CW + 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  sched_state_t  state;
  logic [15:0]   steps_q;
  logic [JW-1:0] job_k;       // index of the job currently being computed
  logic [CW-1:0] job_chunk;   // chunk of job k
  logic          job_bank;    // bank of job k
  logic          arm;         // raise the requests of the current state next edge
  logic          ld_flag;
  logic          cp_flag;

  logic [JW-1:0] total_jobs;
  logic [CW-1:0] next_chunk;
  logic          ld_hit, cp_hit, ld_ok, cp_ok;

  assign total_jobs = JW'(steps_q) * JW'(NUM_CHUNKS);
  assign next_chunk = (job_chunk == LAST_CHUNK) ? '0 : job_chunk + CW'(1);
  // Completion pulses only count while their request is raised.
  assign ld_hit     = ld_done & chunk_transfer_ready;
  assign cp_hit     = cp_done & chunk_compute_ready;
  assign ld_ok      = ld_flag | ld_hit;
  assign cp_ok      = cp_flag | cp_hit;

  // Scheduler FSM, job counter, step counter and registered request outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= ST_IDLE;
      steps_q              <= '0;
      job_k                <= '0;
      job_chunk            <= '0;
      job_bank             <= 1'b0;
      arm                  <= 1'b0;
      ld_flag              <= 1'b0;
      cp_flag              <= 1'b0;
      chunk_transfer_ready <= 1'b0;
      chunk_compute_ready  <= 1'b0;
      ld_bank              <= 1'b0;
      ld_chunk             <= '0;
      cp_bank              <= 1'b0;
      cp_chunk             <= '0;
      step_count           <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cp_hit && cp_chunk == LAST_CHUNK) step_count <= step_count + 16'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            steps_q    <= num_steps;
            step_count <= '0;
            job_k      <= '0;
            job_chunk  <= '0;
            job_bank   <= 1'b0;
            ld_flag    <= 1'b0;
            cp_flag    <= 1'b0;
            busy       <= 1'b1;
            if (num_steps == 16'd0) begin
              state <= ST_FINISH;
            end else begin
              state <= ST_PRIME;
              arm   <= 1'b1;
            end
          end
        end
        ST_PRIME: begin
          if (arm) begin
            arm                  <= 1'b0;
            chunk_transfer_ready <= 1'b1;
            ld_chunk             <= job_chunk;
            ld_bank              <= job_bank;
          end else if (ld_hit) begin
            chunk_transfer_ready <= 1'b0;
            arm                  <= 1'b1;
            state                <= (total_jobs > JW'(1)) ? ST_OVERLAP : ST_LAST;
          end
        end
        ST_OVERLAP: begin
          if (arm) begin
            arm                  <= 1'b0;
            chunk_transfer_ready <= 1'b1;
            chunk_compute_ready  <= 1'b1;
            ld_chunk             <= next_chunk;
            ld_bank              <= ~job_bank;
            cp_chunk             <= job_chunk;
            cp_bank              <= job_bank;
          end else begin
            if (ld_hit) begin
              chunk_transfer_ready <= 1'b0;
              ld_flag              <= 1'b1;
            end
            if (cp_hit) begin
              chunk_compute_ready <= 1'b0;
              cp_flag             <= 1'b1;
            end
            if (ld_ok && cp_ok) begin
              ld_flag   <= 1'b0;
              cp_flag   <= 1'b0;
              arm       <= 1'b1;
              job_k     <= job_k + JW'(1);
              job_chunk <= next_chunk;
              job_bank  <= ~job_bank;
              state     <= (job_k + JW'(2) < total_jobs) ? ST_OVERLAP : ST_LAST;
            end
          end
        end
        ST_LAST: begin
          if (arm) begin
            arm                 <= 1'b0;
            chunk_compute_ready <= 1'b1;
            cp_chunk            <= job_chunk;
            cp_bank             <= job_bank;
          end else if (cp_hit) begin
            chunk_compute_ready <= 1'b0;
            state               <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lbm_bank_mux #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_bank_mux (
    .ld_req    (chunk_transfer_ready),
    .ld_bank   (ld_bank),
    .ld_addr   (ld_addr),
    .ld_we     (ld_we),
    .cp_req    (chunk_compute_ready),
    .cp_bank   (cp_bank),
    .cp_addr   (cp_addr),
    .cp_we     (cp_we),
    .bank_addr0(bank_addr0),
    .bank_addr1(bank_addr1),
    .bank_we   (bank_we)
  );

endmodule

// File: tb/tb_lbm_chunk_scheduler.sv
// Randomized bench for lbm_chunk_scheduler with a job-level timing model.
module tb_lbm_chunk_scheduler;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [15:0]   num_steps;
  logic          chunk_transfer_ready, ld_done, ld_bank;
  logic [CW-1:0] ld_chunk;
  logic          chunk_compute_ready, cp_done, cp_bank;
  logic [CW-1:0] cp_chunk;
  logic [AW-1:0] ld_addr, cp_addr;
  logic          ld_we, cp_we;
  logic [AW-1:0] bank_addr0, bank_addr1;
  logic [1:0]    bank_we;
  logic [15:0]   step_count;
  logic          busy, done;

  int tests = 0;
  int fails = 0;
  int ld_dn [0:255];
  int cp_dn [0:255];

  always #5 clk = ~clk;

  lbm_chunk_scheduler #(.NUM_CHUNKS(NC), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_steps(num_steps),
    .chunk_transfer_ready(chunk_transfer_ready), .ld_done(ld_done),
    .ld_bank(ld_bank), .ld_chunk(ld_chunk),
    .chunk_compute_ready(chunk_compute_ready), .cp_done(cp_done),
    .cp_bank(cp_bank), .cp_chunk(cp_chunk),
    .ld_addr(ld_addr), .cp_addr(cp_addr), .ld_we(ld_we), .cp_we(cp_we),
    .bank_addr0(bank_addr0), .bank_addr1(bank_addr1), .bank_we(bank_we),
    .step_count(step_count), .busy(busy), .done(done)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Responder latency per mode: 0 random, 1 fixed 5, 2 equal (same-cycle), 3 compute early.
  function automatic int lat(input int mode, input bit is_ld);
    case (mode)
      1:       return 5;
      2:       return 3;
      3:       return is_ld ? 11 : 1;
      default: return int'($urandom_range(0, 6));
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, "_ld_req"}, int'(chunk_transfer_ready), 0);
    check_val({tag, "_cp_req"}, int'(chunk_compute_ready), 0);
    check_val({tag, "_ld_bank"}, int'(ld_bank), 0);
    check_val({tag, "_ld_chunk"}, int'(ld_chunk), 0);
    check_val({tag, "_cp_bank"}, int'(cp_bank), 0);
    check_val({tag, "_cp_chunk"}, int'(cp_chunk), 0);
    check_val({tag, "_addr0"}, int'(bank_addr0), 0);
    check_val({tag, "_addr1"}, int'(bank_addr1), 0);
    check_val({tag, "_we"}, int'(bank_we), 0);
    check_val({tag, "_step_count"}, int'(step_count), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_done"}, int'(done), 0);
  endtask

  // Each bank port carries the loader if it owns that bank, else the solver, else nothing.
  task automatic check_mux();
    int ea0, ea1, ew0, ew1;
    ea0 = 0; ea1 = 0; ew0 = 0; ew1 = 0;
    if (chunk_transfer_ready && ld_bank == 1'b0) begin ea0 = int'(ld_addr); ew0 = int'(ld_we); end
    else if (chunk_compute_ready && cp_bank == 1'b0) begin ea0 = int'(cp_addr); ew0 = int'(cp_we); end
    if (chunk_transfer_ready && ld_bank == 1'b1) begin ea1 = int'(ld_addr); ew1 = int'(ld_we); end
    else if (chunk_compute_ready && cp_bank == 1'b1) begin ea1 = int'(cp_addr); ew1 = int'(cp_we); end
    check_val("mux_addr0", int'(bank_addr0), ea0);
    check_val("mux_addr1", int'(bank_addr1), ea1);
    check_val("mux_we", int'(bank_we), ew1 * 2 + ew0);
  endtask

  task automatic do_abort();
    #2 rstn = 1'b0;
    #1 check_zero("abort");
    ld_done = 1'b0; cp_done = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("post_abort_done", int'(done), 0);
      check_val("post_abort_busy", int'(busy), 0);
      check_val("post_abort_ld_req", int'(chunk_transfer_ready), 0);
    end
  endtask

  // One run of num_steps=steps. Job j is chunk j%NC in bank j%2. A request set is
  // raised 2 negedges after the later of the completions it waits for.
  task automatic run_job(input int steps, input int mode, input int abort_ld);
    int  t_jobs, ldr, cpr, ld_wait, cp_wait, exp_t;
    bit  ld_prev, cp_prev, ld_fired, cp_fired, finished;
    t_jobs = NC * steps;
    ldr = 0; cpr = 0; ld_wait = 0; cp_wait = 0;
    ld_prev = 0; cp_prev = 0; ld_fired = 0; cp_fired = 0; finished = 0;
    for (int i = 0; i < 256; i++) begin ld_dn[i] = -100; cp_dn[i] = -100; end
    @(negedge clk);
    start = 1'b1; num_steps = 16'(steps); ld_done = 1'b0; cp_done = 1'b0;
    for (int n = 1; n <= 3000 && !finished; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (ld_fired) check_val("ld_req_fall", int'(chunk_transfer_ready), 0);
      if (cp_fired) check_val("cp_req_fall", int'(chunk_compute_ready), 0);
      ld_fired = 0; cp_fired = 0; ld_done = 1'b0; cp_done = 1'b0;
      if (done) begin
        exp_t = (t_jobs == 0) ? 2 : cp_dn[t_jobs-1] + 2;
        check_val("done_time", n, exp_t);
        check_val("done_busy", int'(busy), 0);
        check_val("step_count", int'(step_count), steps & 16'hFFFF);
        check_val("load_count", ldr, t_jobs);
        check_val("compute_count", cpr, t_jobs);
        finished = 1;
      end else begin
        check_val("busy", int'(busy), 1);
        if (chunk_transfer_ready && !ld_prev) begin
          if (ldr >= t_jobs) check_val("load_count", ldr + 1, t_jobs);
          else begin
            check_val("ld_chunk", int'(ld_chunk), ldr % NC);
            check_val("ld_bank", int'(ld_bank), ldr % 2);
            exp_t = (ldr == 0) ? 2 : imax(ld_dn[ldr-1], (ldr >= 2) ? cp_dn[ldr-2] : 0) + 2;
            check_val("ld_rise_time", n, exp_t);
            if (abort_ld == ldr) begin
              do_abort();
              return;
            end
            ld_wait = lat(mode, 1'b1);
            ldr++;
          end
        end
        if (chunk_compute_ready && !cp_prev) begin
          if (cpr >= t_jobs) check_val("compute_count", cpr + 1, t_jobs);
          else begin
            check_val("cp_chunk", int'(cp_chunk), cpr % NC);
            check_val("cp_bank", int'(cp_bank), cpr % 2);
            exp_t = imax(ld_dn[cpr], (cpr >= 1) ? cp_dn[cpr-1] : 0) + 2;
            check_val("cp_rise_time", n, exp_t);
            cp_wait = lat(mode, 1'b0);
            cpr++;
          end
        end
        if (chunk_transfer_ready && ldr > 0) begin
          if (ld_wait == 0) begin ld_done = 1'b1; ld_dn[ldr-1] = n; ld_fired = 1; end
          else ld_wait--;
        end else if (!chunk_transfer_ready && mode == 0 && $urandom_range(0, 5) == 0) ld_done = 1'b1;
        if (chunk_compute_ready && cpr > 0) begin
          if (cp_wait == 0) begin cp_done = 1'b1; cp_dn[cpr-1] = n; cp_fired = 1; end
          else cp_wait--;
        end else if (!chunk_compute_ready && mode == 0 && $urandom_range(0, 5) == 0) cp_done = 1'b1;
        if (chunk_transfer_ready && chunk_compute_ready)
          check_val("bank_split", int'(ld_bank != cp_bank), 1);
        if (mode == 0 && $urandom_range(0, 9) == 0) begin
          start = 1'b1; num_steps = 16'($urandom_range(0, 7));
        end
        ld_addr = AW'($urandom); cp_addr = AW'($urandom);
        ld_we = 1'($urandom); cp_we = 1'($urandom);
        #1 check_mux();
      end
      ld_prev = chunk_transfer_ready;
      cp_prev = chunk_compute_ready;
    end
    if (!finished) check_val("run_timeout", 0, 1);
    @(negedge clk);
    check_val("done_width", int'(done), 0);
    check_val("idle_busy", int'(busy), 0);
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; num_steps = 16'd0;
    ld_done = 1'b0; cp_done = 1'b0;
    ld_addr = 8'hA5; cp_addr = 8'h3C; ld_we = 1'b1; cp_we = 1'b1;
    #2 rstn = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_job(2, 1, -1);   // 8 jobs, fixed latency
    run_job(3, 2, -1);   // simultaneous completions in overlap
    run_job(2, 3, -1);   // compute finishes long before the load
    run_job(0, 0, -1);   // empty run
    run_job(3, 0, 4);    // reset while loading job 4 / computing job 3
    run_job(2, 0, -1);   // fresh run after the abort
    for (int r = 0; r < 6; r++) run_job(int'($urandom_range(1, 5)), 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
